fsm_dispatcher: RTL and testbench

Initiator-side companion to the three-state run controller (IDLE=0, RUN=1, DONE=2). It accepts job requests over a valid/ready interface and queues them as a pending count. It issues one-cycle `start` pulses to the controller and tracks the controller's 2-bit state output through each IDLE→RUN→DONE→IDLE round trip. It also counts completions and flags protocol violations (illegal encoding, out-of-order state, timeout).

---
 rtl/fsm_dispatcher.sv | 165 ++++++++++++++++
 tb/tb_fsm_dispatcher.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_dispatcher.sv
// fsm_dispatcher
//   Initiator-side companion to a three-state run controller (IDLE=0, RUN=1,
//   DONE=2). Job requests are counted into a pending pool. One job at a time
//   is issued with a one-cycle start pulse. The controller's state is then
//   followed through IDLE -> RUN -> DONE -> IDLE. Completions are counted, and
//   protocol violations park the block in ERR until err_clr.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   req_valid   job request
//   req_ready   request can be taken (pending < DEPTH)
//   err_clr     leave ERR (ignored elsewhere)
//   fsm_state   controller state (0 idle, 1 run, 2 done, 3 illegal)
//   start       one-cycle issue pulse, high only in ISSUE
//   busy        dispatcher neither IDLE nor ERR
//   done_pulse  one-cycle pulse per completed job
//   done_count  completed jobs, wraps
//   pending     accepted but not yet issued requests
//   err         high in ERR
//   err_code    0 none, 1 illegal encoding, 2 timeout, 3 out-of-order
//   dbg_state   current dispatcher state, for observation
//
// Handshake: a request is taken on any rising edge where req_valid and
// req_ready are both high. req_ready depends only on the registered pending
// count, so it never depends combinationally on req_valid.
module fsm_dispatcher #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 8,
   localparam int PW     = $clog2(DEPTH + 1),
   localparam int TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             err_clr,
   input  logic [1:0]       fsm_state,
   output logic             start,
   output logic             busy,
   output logic             done_pulse,
   output logic [CNT_W-1:0] done_count,
   output logic [PW-1:0]    pending,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_RUN  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_WAIT_IDLE = 3'd4,
      S_ERR       = 3'd5
   } state_t;

   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_RUN  = 2'd1;
   localparam logic [1:0] C_DONE = 2'd2;
   localparam logic [1:0] C_BAD  = 2'd3;

   localparam logic [1:0] E_NONE  = 2'd0;
   localparam logic [1:0] E_ILL   = 2'd1;
   localparam logic [1:0] E_TMO   = 2'd2;
   localparam logic [1:0] E_ORDER = 2'd3;

   state_t          state, state_d;
   logic [1:0]      code_d;
   logic [TW-1:0]   tcnt, tcnt_d;
   logic            tmo;
   logic            do_done;
   logic            accept;
   logic            issue;
   logic            in_wait_d;

   assign req_ready = (pending < PW'(DEPTH));
   assign accept    = req_valid && req_ready;
   assign busy      = (state != S_IDLE) && (state != S_ERR);
   assign err       = (state == S_ERR);
   assign dbg_state = state;

   // Timeout fires on the last allowed cycle of a wait state, so no wait
   // state is ever held for more than TIMEOUT cycles.
   assign tmo = (tcnt == TW'(TIMEOUT - 1));

   always_comb begin
      state_d = state;
      code_d  = err_code;
      do_done = 1'b0;
      case (state)
         S_IDLE: begin
            if ((pending != '0) && (fsm_state == C_IDLE)) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            state_d = S_WAIT_RUN;
         end
         S_WAIT_RUN: begin
            case (fsm_state)
               C_RUN:   state_d = S_WAIT_DONE;
               C_DONE:  begin state_d = S_ERR; code_d = E_ORDER; end
               default: if (tmo) begin state_d = S_ERR; code_d = E_TMO; end
            endcase
         end
         S_WAIT_DONE: begin
            case (fsm_state)
               C_DONE:  begin state_d = S_WAIT_IDLE; do_done = 1'b1; end
               C_IDLE:  begin state_d = S_ERR; code_d = E_ORDER; end
               default: if (tmo) begin state_d = S_ERR; code_d = E_TMO; end
            endcase
         end
         S_WAIT_IDLE: begin
            case (fsm_state)
               C_IDLE:  state_d = (pending != '0) ? S_ISSUE : S_IDLE;
               C_RUN:   begin state_d = S_ERR; code_d = E_ORDER; end
               default: if (tmo) begin state_d = S_ERR; code_d = E_TMO; end
            endcase
         end
         S_ERR: begin
            if (err_clr) begin
               state_d = S_IDLE;
               code_d  = E_NONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            code_d  = E_NONE;
         end
      endcase
      // Illegal encoding outranks every other outcome outside ERR.
      if ((state != S_ERR) && (fsm_state == C_BAD)) begin
         state_d = S_ERR;
         code_d  = E_ILL;
         do_done = 1'b0;
      end
   end

   assign issue     = (state_d == S_ISSUE);
   assign in_wait_d = (state_d == S_WAIT_RUN) || (state_d == S_WAIT_DONE) ||
                      (state_d == S_WAIT_IDLE);
   // Counter restarts whenever a wait state is (re)entered.
   assign tcnt_d    = (in_wait_d && (state_d == state)) ? tcnt + TW'(1) : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         err_code   <= E_NONE;
         tcnt       <= '0;
         start      <= 1'b0;
         done_pulse <= 1'b0;
         done_count <= '0;
         pending    <= '0;
      end else begin
         state      <= state_d;
         err_code   <= code_d;
         tcnt       <= tcnt_d;
         start      <= issue;
         done_pulse <= do_done;
         if (do_done) done_count <= done_count + CNT_W'(1);
         pending    <= pending + PW'(accept) - PW'(issue);
      end
   end

endmodule

// File: tb/tb_fsm_dispatcher.sv
module tb_fsm_dispatcher;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 8;
   localparam int PW      = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             err_clr = 1'b0;
   logic [1:0]       fsm_state;
   logic             start;
   logic             busy;
   logic             done_pulse;
   logic [CNT_W-1:0] done_count;
   logic [PW-1:0]    pending;
   logic             err;
   logic [1:0]       err_code;
   logic [2:0]       dbg_state;

   int errors = 0;
   int checks = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- controller model ----------------
   // Conforming controller: start -> RUN, one cycle RUN, one cycle DONE, IDLE.
   // ovr replaces its output with ovr_val and holds it idle meanwhile.
   logic [1:0] ctl_q;
   bit         ovr = 1'b0;
   logic [1:0] ovr_val = 2'd0;
   assign fsm_state = ovr ? ovr_val : ctl_q;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)            ctl_q <= 2'd0;
      else if (ovr)            ctl_q <= 2'd0;
      else if (start)          ctl_q <= 2'd1;
      else if (ctl_q == 2'd1)  ctl_q <= 2'd2;
      else if (ctl_q == 2'd2)  ctl_q <= 2'd0;
   end

   fsm_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .err_clr(err_clr), .fsm_state(fsm_state), .start(start), .busy(busy),
      .done_pulse(done_pulse), .done_count(done_count), .pending(pending),
      .err(err), .err_code(err_code), .dbg_state(dbg_state)
   );

   // ---------------- reference model (transaction level) ----------------
   // With a conforming controller a job occupies the dispatcher for 4 edges
   // starting at its issue edge; completion lands 3 edges after issue. A new
   // issue needs a queued job and at least 4 edges since the previous issue.
   int n;
   int m_last;
   int m_pend;
   int m_done;
   bit saw_full;
   logic [CNT_W-1:0] exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = 1'b0;
      err_clr   = 1'b0;
      ovr       = 1'b0;
      ovr_val   = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      reset_n  = 1'b1;
      n        = 0;
      m_last   = -100;
      m_pend   = 0;
      m_done   = 0;
      saw_full = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_cycle(input bit rv);
      bit iss, acc, dp, bz;
      logic [CNT_W-1:0] exp_cnt;
      req_valid = rv;
      tick();
      n++;
      iss = (m_pend > 0) && (n - m_last >= 4);
      dp  = (n - m_last == 3);
      acc = rv && (m_pend < DEPTH);
      if (rv && !acc) saw_full = 1'b1;
      if (dp) begin
         m_done++;
         exp_q.push_back(CNT_W'(m_done));
      end
      if (iss) m_last = n;
      m_pend = m_pend + int'(acc) - int'(iss);
      bz = (n - m_last <= 3);
      checks++;
      if (start !== iss) begin
         errors++; $display("FAIL start n=%0d got=%b exp=%b", n, start, iss);
      end
      checks++;
      if (done_pulse !== dp) begin
         errors++; $display("FAIL done_pulse n=%0d got=%b exp=%b", n, done_pulse, dp);
      end
      checks++;
      if (pending !== PW'(m_pend)) begin
         errors++; $display("FAIL pending n=%0d got=%0d exp=%0d", n, pending, m_pend);
      end
      checks++;
      if (done_count !== CNT_W'(m_done)) begin
         errors++; $display("FAIL done_count n=%0d got=%0d exp=%0d", n, done_count, CNT_W'(m_done));
      end
      checks++;
      if (busy !== bz) begin
         errors++; $display("FAIL busy n=%0d got=%b exp=%b", n, busy, bz);
      end
      checks++;
      if (req_ready !== (m_pend < DEPTH)) begin
         errors++; $display("FAIL req_ready n=%0d got=%b exp=%b", n, req_ready, (m_pend < DEPTH));
      end
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL err n=%0d got=%b exp=0", n, err);
      end
      // scoreboard: each observed done pulse must match the next expected count
      if (done_pulse === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL sb_unexpected_done n=%0d count=%0d exp=none", n, done_count);
         end else begin
            exp_cnt = exp_q.pop_front();
            if (done_count !== exp_cnt) begin
               errors++; $display("FAIL sb_done_count n=%0d got=%0d exp=%0d", n, done_count, exp_cnt);
            end
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      reset_n = 1'b0;
      #1;
      checks++;
      if ({start, done_pulse, err, busy, req_ready} !== 5'b00001) begin
         errors++; $display("FAIL reset_flags got=%b exp=00001", {start, done_pulse, err, busy, req_ready});
      end
      checks++;
      if ({done_count, pending, err_code} !== '0) begin
         errors++; $display("FAIL reset_values got=%0d/%0d/%0d exp=0/0/0", done_count, pending, err_code);
      end
      checks++;
      if (dbg_state !== 3'd0) begin
         errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      model_cycle(1'b1);
      for (int i = 0; i < 7; i++) model_cycle(1'b0);
      checks++;
      if ({done_count, pending, busy} !== {CNT_W'(1), PW'(0), 1'b0}) begin
         errors++; $display("FAIL single_end got=%0d/%0d/%b exp=1/0/0", done_count, pending, busy);
      end
   endtask

   task automatic test_simul();
      do_reset();
      model_cycle(1'b1);
      model_cycle(1'b1);
      checks++;
      if ({start, pending} !== {1'b1, PW'(1)}) begin
         errors++; $display("FAIL simul_accept_issue got=%b/%0d exp=1/1", start, pending);
      end
      for (int i = 0; i < 10; i++) model_cycle(1'b0);
   endtask

   task automatic test_backpressure();
      int acc_total;
      do_reset();
      acc_total = 0;
      for (int i = 0; i < 40; i++) begin
         if (acc_total < 6) begin
            if (req_ready) acc_total++;
            model_cycle(1'b1);
         end else begin
            model_cycle(1'b0);
         end
      end
      checks++;
      if (saw_full !== 1'b1) begin
         errors++; $display("FAIL bp_ready_low got=%b exp=1", saw_full);
      end
      checks++;
      if (done_count !== CNT_W'(6)) begin
         errors++; $display("FAIL bp_done_count got=%0d exp=6", done_count);
      end
   endtask

   task automatic test_random();
      int dens;
      do_reset();
      for (int seg = 0; seg < 6; seg++) begin
         dens = $urandom_range(5, 95);
         for (int i = 0; i < 50; i++) model_cycle($urandom_range(0, 99) < dens);
      end
      for (int i = 0; i < 40; i++) model_cycle(1'b0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL rand_sb_leftover got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 1100; i++) model_cycle(1'b1);
      checks++;
      if (m_done <= 256 || done_count !== CNT_W'(m_done)) begin
         errors++; $display("FAIL wrap got=%0d exp=%0d jobs=%0d", done_count, CNT_W'(m_done), m_done);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      req_valid = 1'b1; tick();          // accept
      tick();                            // issue + accept
      req_valid = 1'b0;
      tick(); tick();                    // WAIT_RUN, WAIT_DONE
      checks++;
      if ({busy, err} !== 2'b10) begin
         errors++; $display("FAIL ill_pre got=%b exp=10", {busy, err});
      end
      ovr = 1'b1; ovr_val = 2'd3;
      tick();
      checks++;
      if ({err, err_code, start, busy} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
         errors++; $display("FAIL ill_err got=%b/%0d/%b/%b exp=1/1/0/0", err, err_code, start, busy);
      end
      checks++;
      if (done_count !== CNT_W'(0)) begin
         errors++; $display("FAIL ill_done_count got=%0d exp=0", done_count);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({err, err_code, start, pending} !== {1'b1, 2'd1, 1'b0, PW'(1)}) begin
            errors++; $display("FAIL ill_hold i=%0d got=%b/%0d/%b/%0d exp=1/1/0/1", i, err, err_code, start, pending);
         end
      end
      ovr = 1'b0; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if ({err, err_code, busy, pending} !== {1'b0, 2'd0, 1'b0, PW'(1)}) begin
         errors++; $display("FAIL ill_clear got=%b/%0d/%b/%0d exp=0/0/0/1", err, err_code, busy, pending);
      end
      tick();
      checks++;
      if ({start, pending} !== {1'b1, PW'(0)}) begin
         errors++; $display("FAIL ill_resume got=%b/%0d exp=1/0", start, pending);
      end
      tick(); tick(); tick();
      checks++;
      if ({done_pulse, done_count} !== {1'b1, CNT_W'(1)}) begin
         errors++; $display("FAIL ill_resume_done got=%b/%0d exp=1/1", done_pulse, done_count);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      ovr = 1'b1; ovr_val = 2'd0;
      req_valid = 1'b1; tick();
      req_valid = 1'b0;
      tick();
      checks++;
      if (start !== 1'b1) begin
         errors++; $display("FAIL tmo_start got=%b exp=1", start);
      end
      tick();
      for (int i = 0; i < TIMEOUT; i++) begin
         checks++;
         if ({err, busy} !== 2'b01) begin
            errors++; $display("FAIL tmo_wait i=%0d got=%b exp=01", i, {err, busy});
         end
         tick();
      end
      checks++;
      if ({err, err_code, start} !== {1'b1, 2'd2, 1'b0}) begin
         errors++; $display("FAIL tmo_err got=%b/%0d/%b exp=1/2/0", err, err_code, start);
      end
      ovr = 1'b0; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if ({err, err_code} !== {1'b0, 2'd0}) begin
         errors++; $display("FAIL tmo_clear got=%b/%0d exp=0/0", err, err_code);
      end
   endtask

   task automatic test_out_of_order();
      do_reset();
      req_valid = 1'b1; tick();
      req_valid = 1'b0;
      tick();                            // ISSUE
      tick();                            // WAIT_RUN
      ovr = 1'b1; ovr_val = 2'd2;        // controller jumps straight to DONE
      tick();
      checks++;
      if ({err, err_code, done_pulse} !== {1'b1, 2'd3, 1'b0}) begin
         errors++; $display("FAIL ooo_err got=%b/%0d/%b exp=1/3/0", err, err_code, done_pulse);
      end
      checks++;
      if (done_count !== CNT_W'(0)) begin
         errors++; $display("FAIL ooo_done_count got=%0d exp=0", done_count);
      end
      ovr = 1'b0; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      model_cycle(1'b1);
      for (int i = 0; i < 6; i++) model_cycle(1'b0);
      model_cycle(1'b1);
      model_cycle(1'b1);
      model_cycle(1'b1);
      model_cycle(1'b0);                 // now in WAIT_DONE with 2 queued
      checks++;
      if ({busy, pending, done_count} !== {1'b1, PW'(2), CNT_W'(1)}) begin
         errors++; $display("FAIL mid_pre got=%b/%0d/%0d exp=1/2/1", busy, pending, done_count);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({start, done_pulse, err, busy, req_ready} !== 5'b00001) begin
         errors++; $display("FAIL mid_flags got=%b exp=00001", {start, done_pulse, err, busy, req_ready});
      end
      checks++;
      if ({done_count, pending, err_code} !== '0) begin
         errors++; $display("FAIL mid_values got=%0d/%0d/%0d exp=0/0/0", done_count, pending, err_code);
      end
      tick();
      reset_n = 1'b1;
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_single();
      test_simul();
      test_backpressure();
      test_illegal();
      test_timeout();
      test_out_of_order();
      test_random();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
